// File: rtl/vga_timing_generator_if.sv
// Bus between the colour-manager assign-data block and the VGA timing generator.
// Define VGA_FRAME_COUNTER_EN to add the frame_count signal.
interface vga_timing_generator_if #(
  parameter int unsigned CounterWidth    = 11,
  parameter int unsigned DataWidth       = 12,
  parameter int unsigned BackPorchWidth  = 11,
  parameter int unsigned FrontPorchWidth = 11
);
  logic                       pix_en;
  logic [BackPorchWidth-1:0]  h_back_porch;
  logic [FrontPorchWidth-1:0] h_front_porch;
  logic [BackPorchWidth-1:0]  v_back_porch;
  logic [FrontPorchWidth-1:0] v_front_porch;
  logic [DataWidth-1:0]       data_vga;
  logic [CounterWidth-1:0]    counter_x;
  logic                       counter_x_valid;
  logic [CounterWidth-1:0]    counter_y;
  logic                       counter_y_valid;
  logic                       hsync;
  logic                       vsync;
  logic [DataWidth-1:0]       rgb;
  logic                       timing_error;
`ifdef VGA_FRAME_COUNTER_EN
  logic [15:0]                frame_count;
`endif

  modport master (
    output pix_en, h_back_porch, h_front_porch, v_back_porch, v_front_porch, data_vga,
    input  counter_x, counter_x_valid, counter_y, counter_y_valid, hsync, vsync, rgb,
           timing_error
`ifdef VGA_FRAME_COUNTER_EN
    , input frame_count
`endif
  );

  modport slave (
    input  pix_en, h_back_porch, h_front_porch, v_back_porch, v_front_porch, data_vga,
    output counter_x, counter_x_valid, counter_y, counter_y_valid, hsync, vsync, rgb,
           timing_error
`ifdef VGA_FRAME_COUNTER_EN
    , output frame_count
`endif
  );
endinterface

// File: rtl/vga_timing_generator.sv
// VGA pixel/line counters, registered syncs and gated RGB; porch timing is shadowed at frame start.
// Define VGA_FRAME_COUNTER_EN to add a 16-bit frame_count output.
module vga_timing_generator #(
  parameter int unsigned CounterWidth    = 11,
  parameter int unsigned DataWidth       = 12,
  parameter int unsigned BackPorchWidth  = 11,
  parameter int unsigned FrontPorchWidth = 11,
  parameter int unsigned HSyncPulse      = 96,
  parameter int unsigned VSyncPulse      = 2,
  parameter bit          SyncPolarity    = 1'b0
) (
  input logic                   clk_i,
  input logic                   rst_i,
  vga_timing_generator_if.slave vga_io
);

  typedef enum logic [1:0] {StLoad, StCheck, StRun} state_e;
  state_e state_q, state_d;

  logic [BackPorchWidth-1:0]  h_total_q, h_total_d, v_total_q, v_total_d;
  logic [FrontPorchWidth-1:0] h_act_q, h_act_d, v_act_q, v_act_d;
  logic [CounterWidth-1:0]    x_q, x_d, y_q, y_d;
  logic                       hsync_q, hsync_d, vsync_q, vsync_d;
  logic                       active_q, active_d;
  logic [DataWidth-1:0]       rgb_q, rgb_d;
  logic                       err_q, err_d;

  logic [CounterWidth-1:0] h_total_c, h_act_c, v_total_c, v_act_c;
  logic timing_legal, tick, x_last, y_last, frame_wrap;
  logic in_sync_h, in_sync_v, x_valid, y_valid;

  assign h_total_c = CounterWidth'(h_total_q);
  assign h_act_c   = CounterWidth'(h_act_q);
  assign v_total_c = CounterWidth'(v_total_q);
  assign v_act_c   = CounterWidth'(v_act_q);

  // Widened to 32 bits so act + pulse cannot overflow the compare.
  assign timing_legal = (h_act_c != '0) && (v_act_c != '0) &&
                        (32'(h_act_c) + HSyncPulse <= 32'(h_total_c)) &&
                        (32'(v_act_c) + VSyncPulse <= 32'(v_total_c));

  assign tick       = (state_q == StRun) && vga_io.pix_en;
  assign x_last     = (x_q == h_total_c - CounterWidth'(1));
  assign y_last     = (y_q == v_total_c - CounterWidth'(1));
  assign frame_wrap = tick && x_last && y_last;
  assign in_sync_h  = 32'(x_q) >= 32'(h_total_c) - HSyncPulse;
  assign in_sync_v  = 32'(y_q) >= 32'(v_total_c) - VSyncPulse;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= StLoad;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StLoad:  state_d = StCheck;
      StCheck: state_d = timing_legal ? StRun : StLoad;
      StRun:   if (frame_wrap) state_d = StLoad;
      default: state_d = StLoad;
    endcase
  end

  always_comb begin
    x_valid = 1'b0;
    y_valid = 1'b0;
    if (state_q == StRun) begin
      x_valid = (x_q < h_act_c);
      y_valid = (y_q < v_act_c);
    end
  end

  always_comb begin
    h_total_d = h_total_q;
    h_act_d   = h_act_q;
    v_total_d = v_total_q;
    v_act_d   = v_act_q;
    x_d       = x_q;
    y_d       = y_q;
    hsync_d   = hsync_q;
    vsync_d   = vsync_q;
    active_d  = active_q;
    rgb_d     = rgb_q;
    err_d     = err_q;
    if (state_q == StLoad) begin
      h_total_d = vga_io.h_back_porch;
      h_act_d   = vga_io.h_front_porch;
      v_total_d = vga_io.v_back_porch;
      v_act_d   = vga_io.v_front_porch;
    end
    if (state_q == StCheck) begin
      err_d = ~timing_legal;
    end
    // Syncs and the active flag lag the counters one tick to line up with data_vga.
    if (tick) begin
      hsync_d  = in_sync_h ? SyncPolarity : ~SyncPolarity;
      vsync_d  = in_sync_v ? SyncPolarity : ~SyncPolarity;
      active_d = x_valid && y_valid;
      rgb_d    = active_q ? vga_io.data_vga : '0;
      if (x_last) begin
        x_d = '0;
        y_d = y_last ? '0 : y_q + CounterWidth'(1);
      end else begin
        x_d = x_q + CounterWidth'(1);
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      h_total_q <= '0;
      h_act_q   <= '0;
      v_total_q <= '0;
      v_act_q   <= '0;
      x_q       <= '0;
      y_q       <= '0;
      hsync_q   <= ~SyncPolarity;
      vsync_q   <= ~SyncPolarity;
      active_q  <= 1'b0;
      rgb_q     <= '0;
      err_q     <= 1'b0;
    end else begin
      h_total_q <= h_total_d;
      h_act_q   <= h_act_d;
      v_total_q <= v_total_d;
      v_act_q   <= v_act_d;
      x_q       <= x_d;
      y_q       <= y_d;
      hsync_q   <= hsync_d;
      vsync_q   <= vsync_d;
      active_q  <= active_d;
      rgb_q     <= rgb_d;
      err_q     <= err_d;
    end
  end

`ifdef VGA_FRAME_COUNTER_EN
  logic [15:0] frame_cnt_q, frame_cnt_d;

  always_comb begin
    frame_cnt_d = frame_cnt_q;
    if (frame_wrap && !err_q) frame_cnt_d = frame_cnt_q + 16'd1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      frame_cnt_q <= '0;
    end else begin
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign vga_io.frame_count = frame_cnt_q;
`endif

  assign vga_io.counter_x       = x_q;
  assign vga_io.counter_x_valid = x_valid;
  assign vga_io.counter_y       = y_q;
  assign vga_io.counter_y_valid = y_valid;
  assign vga_io.hsync           = hsync_q;
  assign vga_io.vsync           = vsync_q;
  assign vga_io.rgb             = rgb_q;
  assign vga_io.timing_error    = err_q;

endmodule

// File: tb/tb_vga_timing_generator.sv
// Self-checking bench for vga_timing_generator: linear pixel-position reference model plus
// frame-level measurements (period, valid/sync/RGB counts). Honours VGA_FRAME_COUNTER_EN.
module tb_vga_timing_generator;
  localparam int unsigned CW = 11;
  localparam int unsigned DW = 12;
  localparam int unsigned BW = 11;
  localparam int unsigned FW = 11;
  localparam int HP = 2;
  localparam int VP = 1;
`ifdef VGA_FRAME_COUNTER_EN
  localparam int unsigned OW = 2 * CW + DW + 5 + 16;
`else
  localparam int unsigned OW = 2 * CW + DW + 5;
`endif

  typedef struct {
    int events, period, xv_cnt, hs_low, vs_low, rgb_hits, pre_wide, bad;
    logic [OW-1:0] bad_dut, bad_ref;
  } stats_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  vga_timing_generator_if #(.CounterWidth(CW), .DataWidth(DW), .BackPorchWidth(BW),
                            .FrontPorchWidth(FW)) vga_if ();

  vga_timing_generator #(
    .CounterWidth(CW), .DataWidth(DW), .BackPorchWidth(BW), .FrontPorchWidth(FW),
    .HSyncPulse(HP), .VSyncPulse(VP), .SyncPolarity(1'b0)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .vga_io(vga_if)
  );

  // Reference model: phase 0 = sampling porches, 1 = validating, 2 = scanning by linear position.
  int m_phase, m_pos, m_ht, m_ha, m_vt, m_va;
  logic m_hs, m_vs, m_act_prev, m_err;
  logic [DW-1:0] m_rgb;
  logic [15:0] m_frames;

  task automatic model_reset();
    m_phase = 0; m_pos = 0; m_ht = 0; m_ha = 0; m_vt = 0; m_va = 0;
    m_hs = 1'b1; m_vs = 1'b1; m_act_prev = 1'b0; m_err = 1'b0; m_rgb = '0; m_frames = '0;
  endtask

  task automatic model_edge(input logic pe, input int ht, input int ha, input int vt, input int va,
                            input logic [DW-1:0] data);
    int x, y;
    if (m_phase == 0) begin
      m_ht = ht; m_ha = ha; m_vt = vt; m_va = va;
      m_phase = 1;
    end else if (m_phase == 1) begin
      m_err = !(m_ha > 0 && m_va > 0 && m_ha + HP <= m_ht && m_va + VP <= m_vt);
      m_phase = m_err ? 0 : 2;
    end else if (pe) begin
      x = m_pos % m_ht;
      y = m_pos / m_ht;
      m_hs = (x >= m_ht - HP) ? 1'b0 : 1'b1;
      m_vs = (y >= m_vt - VP) ? 1'b0 : 1'b1;
      m_rgb = m_act_prev ? data : '0;
      m_act_prev = (x < m_ha) && (y < m_va);
      m_pos++;
      if (m_pos == m_ht * m_vt) begin
        m_pos = 0;
        m_phase = 0;
        m_frames = m_frames + 16'd1;
      end
    end
  endtask

  function automatic logic [OW-1:0] model_out();
    int x = 0;
    int y = 0;
    logic xv, yv;
    if (m_phase == 2) begin
      x = m_pos % m_ht;
      y = m_pos / m_ht;
    end
    xv = (m_phase == 2) && (x < m_ha);
    yv = (m_phase == 2) && (y < m_va);
`ifdef VGA_FRAME_COUNTER_EN
    return {CW'(x), xv, CW'(y), yv, m_hs, m_vs, m_rgb, m_err, m_frames};
`else
    return {CW'(x), xv, CW'(y), yv, m_hs, m_vs, m_rgb, m_err};
`endif
  endfunction

  function automatic logic [OW-1:0] dut_out();
`ifdef VGA_FRAME_COUNTER_EN
    return {vga_if.counter_x, vga_if.counter_x_valid, vga_if.counter_y, vga_if.counter_y_valid,
            vga_if.hsync, vga_if.vsync, vga_if.rgb, vga_if.timing_error, vga_if.frame_count};
`else
    return {vga_if.counter_x, vga_if.counter_x_valid, vga_if.counter_y, vga_if.counter_y_valid,
            vga_if.hsync, vga_if.vsync, vga_if.rgb, vga_if.timing_error};
`endif
  endfunction

  // One clock: inputs present before the edge feed the model, outputs settle by #1 after.
  task automatic step();
    logic pe, r;
    int ht, ha, vt, va;
    logic [DW-1:0] d;
    pe = vga_if.pix_en; r = rst; d = vga_if.data_vga;
    ht = int'(vga_if.h_back_porch); ha = int'(vga_if.h_front_porch);
    vt = int'(vga_if.v_back_porch); va = int'(vga_if.v_front_porch);
    @(posedge clk);
    if (r) model_reset();
    else model_edge(pe, ht, ha, vt, va, d);
    #1;
  endtask

  task automatic set_mode(input int ht, input int ha, input int vt, input int va);
    vga_if.h_back_porch  = BW'(ht);
    vga_if.h_front_porch = FW'(ha);
    vga_if.v_back_porch  = BW'(vt);
    vga_if.v_front_porch = FW'(va);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  // Runs until the requested number of frame starts (first cycle showing X=1,Y=0); measures the
  // window between the first and second start and tallies cycles where DUT and model disagree.
  task automatic run_frames(input int events_wanted, input int pe_mode, input bit rand_data,
                            input int max_cycles, input int wide_x, output stats_t s);
    bit prev_ev = 1'b0;
    bit ev;
    int first_cyc = 0;
    s = '{default: 0, bad_dut: '0, bad_ref: '0};
    for (int c = 0; c < max_cycles && s.events < events_wanted; c++) begin
      case (pe_mode)
        0:       vga_if.pix_en = 1'b1;
        1:       vga_if.pix_en = (c % 4 == 0);
        default: vga_if.pix_en = ($urandom_range(1) == 1);
      endcase
      if (rand_data) vga_if.data_vga = DW'($urandom);
      step();
      if (dut_out() !== model_out()) begin
        if (s.bad == 0) begin
          s.bad_dut = dut_out();
          s.bad_ref = model_out();
        end
        s.bad++;
      end
      ev = (vga_if.counter_x == CW'(1)) && (vga_if.counter_y == CW'(0));
      if (ev && !prev_ev) begin
        s.events++;
        if (s.events == 1) first_cyc = c;
        if (s.events == 2) s.period = c - first_cyc;
      end
      if (s.events == 0 && vga_if.counter_x_valid && int'(vga_if.counter_x) >= wide_x)
        s.pre_wide++;
      if (s.events == 1) begin
        if (vga_if.counter_x_valid) s.xv_cnt++;
        if (!vga_if.hsync) s.hs_low++;
        if (!vga_if.vsync) s.vs_low++;
        if (vga_if.rgb != '0) s.rgb_hits++;
      end
      prev_ev = ev;
    end
  endtask

  task automatic test_reset();
    set_mode(16, 10, 8, 4);
    vga_if.pix_en = 1'b1;
    rst = 1'b1;
    model_reset();
    for (int i = 0; i < 2; i++) begin
      step();
      vectors++;
      if (dut_out() !== model_out()) begin
        miscompares++;
        $display("FAIL reset_hold: dut %h expected %h", dut_out(), model_out());
      end
    end
    rst = 1'b0;
    for (int i = 0; i < 45; i++) begin
      vga_if.data_vga = DW'($urandom);
      step();
      vectors++;
      if (dut_out() !== model_out()) begin
        miscompares++;
        $display("FAIL pre_reset_run cycle %0d: dut %h expected %h", i, dut_out(), model_out());
      end
    end
    rst = 1'b1;
    model_reset();
    #1;
    vectors++;
    if (dut_out() !== model_out()) begin
      miscompares++;
      $display("FAIL async_reset: dut %h expected %h", dut_out(), model_out());
    end
    step();
    vectors++;
    if (dut_out() !== model_out()) begin
      miscompares++;
      $display("FAIL reset_held: dut %h expected %h", dut_out(), model_out());
    end
    rst = 1'b0;
  endtask

  task automatic test_small_mode();
    stats_t s;
    set_mode(16, 10, 8, 4);
    do_reset();
    run_frames(2, 0, 1'b1, 1000, 99, s);
    vectors += 6;
    if (s.events !== 2) begin
      miscompares++; $display("FAIL t2_frames: got %0d frame starts, need 2", s.events);
    end
    if (s.bad !== 0) begin
      miscompares++;
      $display("FAIL t2_model: %0d bad cycles, first dut %h expected %h", s.bad, s.bad_dut, s.bad_ref);
    end
    if (s.period !== 130) begin
      miscompares++; $display("FAIL t2_period: got %0d clocks, need 130", s.period);
    end
    if (s.xv_cnt !== 80) begin
      miscompares++; $display("FAIL t2_xvalid: got %0d, need 80", s.xv_cnt);
    end
    if (s.hs_low !== 18) begin
      miscompares++; $display("FAIL t2_hsync_low: got %0d, need 18", s.hs_low);
    end
    if (s.vs_low !== 18) begin
      miscompares++; $display("FAIL t2_vsync_low: got %0d, need 18", s.vs_low);
    end
  endtask

  task automatic test_rgb_gating();
    stats_t s;
    set_mode(16, 10, 8, 4);
    vga_if.data_vga = 12'hABC;
    do_reset();
    run_frames(2, 0, 1'b0, 1000, 99, s);
    vectors += 2;
    if (s.bad !== 0) begin
      miscompares++;
      $display("FAIL t3_model: %0d bad cycles, first dut %h expected %h", s.bad, s.bad_dut, s.bad_ref);
    end
    if (s.rgb_hits !== 40) begin
      miscompares++; $display("FAIL t3_rgb_active: got %0d, need 40", s.rgb_hits);
    end
  endtask

  task automatic test_porch_change();
    stats_t s;
    int guard = 0;
    set_mode(16, 10, 8, 4);
    do_reset();
    run_frames(1, 0, 1'b1, 400, 99, s);
    while (vga_if.counter_y != CW'(2) && guard < 200) begin
      step();
      guard++;
      vectors++;
      if (dut_out() !== model_out()) begin
        miscompares++;
        $display("FAIL t4_to_line2: dut %h expected %h", dut_out(), model_out());
      end
    end
    vectors++;
    if (guard >= 200) begin
      miscompares++; $display("FAIL t4_reach_line2: y %0d after %0d clocks", vga_if.counter_y, guard);
    end
    set_mode(16, 6, 8, 4);
    run_frames(2, 0, 1'b1, 1000, 6, s);
    vectors += 3;
    if (s.bad !== 0) begin
      miscompares++;
      $display("FAIL t4_model: %0d bad cycles, first dut %h expected %h", s.bad, s.bad_dut, s.bad_ref);
    end
    if (s.pre_wide !== 24) begin
      miscompares++; $display("FAIL t4_old_width: got %0d, need 24", s.pre_wide);
    end
    if (s.xv_cnt !== 48) begin
      miscompares++; $display("FAIL t4_new_width: got %0d, need 48", s.xv_cnt);
    end
  endtask

  task automatic test_illegal();
    stats_t s;
    int n = 0;
    set_mode(16, 10, 8, 4);
    do_reset();
    run_frames(1, 0, 1'b1, 400, 99, s);
    set_mode(16, 16, 8, 4);
    while (vga_if.timing_error !== 1'b1 && n < 300) begin
      step();
      n++;
      vectors++;
      if (dut_out() !== model_out()) begin
        miscompares++;
        $display("FAIL t5_to_error: dut %h expected %h", dut_out(), model_out());
      end
    end
    vectors += 2;
    if (n >= 300) begin
      miscompares++; $display("FAIL t5_error_set: timing_error %b after %0d clocks", vga_if.timing_error, n);
    end
    if ({vga_if.counter_x, vga_if.counter_y, vga_if.counter_x_valid, vga_if.counter_y_valid} !== '0) begin
      miscompares++;
      $display("FAIL t5_parked: x %0d y %0d xv %b yv %b, need all 0", vga_if.counter_x,
               vga_if.counter_y, vga_if.counter_x_valid, vga_if.counter_y_valid);
    end
    for (int i = 0; i < 5; i++) begin
      step();
      vectors++;
      if (dut_out() !== model_out()) begin
        miscompares++;
        $display("FAIL t5_parked_cycle %0d: dut %h expected %h", i, dut_out(), model_out());
      end
    end
    set_mode(16, 10, 8, 4);
    n = 0;
    while (vga_if.timing_error !== 1'b0 && n < 4) begin
      step();
      n++;
    end
    vectors++;
    if (vga_if.timing_error !== 1'b0) begin
      miscompares++; $display("FAIL t5_clear: timing_error %b after %0d clocks, need 0", vga_if.timing_error, n);
    end
    run_frames(2, 0, 1'b1, 1000, 99, s);
    vectors += 2;
    if (s.bad !== 0) begin
      miscompares++;
      $display("FAIL t5_model: %0d bad cycles, first dut %h expected %h", s.bad, s.bad_dut, s.bad_ref);
    end
    if (s.period !== 130) begin
      miscompares++; $display("FAIL t5_resume_period: got %0d, need 130", s.period);
    end
  endtask

  task automatic test_pix_en();
    stats_t s;
    set_mode(16, 10, 8, 4);
    do_reset();
    run_frames(4, 1, 1'b1, 3000, 99, s);
    vectors += 3;
    if (s.events !== 4) begin
      miscompares++; $display("FAIL t6_frames: got %0d frame starts, need 4", s.events);
    end
    if (s.bad !== 0) begin
      miscompares++;
      $display("FAIL t6_model: %0d bad cycles, first dut %h expected %h", s.bad, s.bad_dut, s.bad_ref);
    end
    if (s.period !== 512) begin
      miscompares++; $display("FAIL t6_period: got %0d clocks, need 512", s.period);
    end
`ifdef VGA_FRAME_COUNTER_EN
    vectors++;
    if (vga_if.frame_count !== 16'd3) begin
      miscompares++; $display("FAIL t6_frame_count: got %0d, need 3", vga_if.frame_count);
    end
`endif
  endtask

  task automatic test_random_modes();
    int ht, ha, vt, va;
    set_mode(20, 12, 6, 3);
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(199) == 0) begin
        ht = int'($urandom_range(40, HP + 1));
        ha = ($urandom_range(7) == 0) ? ht : int'($urandom_range(ht - HP, 1));
        vt = int'($urandom_range(12, VP + 1));
        va = int'($urandom_range(vt - VP, 1));
        set_mode(ht, ha, vt, va);
      end
      vga_if.pix_en   = ($urandom_range(1) == 1);
      vga_if.data_vga = DW'($urandom);
      step();
      vectors++;
      if (dut_out() !== model_out()) begin
        miscompares++;
        $display("FAIL random_cycle %0d: dut %h expected %h", i, dut_out(), model_out());
      end
    end
  endtask

  initial begin
    vga_if.pix_en   = 1'b0;
    vga_if.data_vga = '0;
    set_mode(16, 10, 8, 4);
    model_reset();
    test_reset();
    test_small_mode();
    test_rgb_gating();
    test_porch_change();
    test_illegal();
    test_pix_en();
    test_random_modes();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
